jk_step_ctrl: RTL and testbench
===============================

Name: jk_step_ctrl

Overview:
- Sequencing controller that sits directly upstream of a W-bit bank of jk_ff instances and drives their j/k inputs.
- Accepts a target value through a valid/ready command interface.
- Moves the bank's state to the target in one of two ways:
  - Step mode: count one per clock, toward the target.
  - Load mode: one-shot set/reset, then verify.
- Reads the bank's q outputs back, reports completion with `done` and failure with `err`.

Parameters:
- W, 4, width of the JK bank / target value.
- MAX_STEPS, 16, maximum excitation cycles in step mode before timeout; must be ≥1.

Ports:
- clk  input  1  clock; rising edge.
- reset  input  1  synchronous, active-high; shared with the JK bank.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept; high only in IDLE and reset low.
- cmd_target  input  W  target value; sampled at accept.
- cmd_mode  input  1  0 = step mode, 1 = load mode; sampled at accept.
- abort  input  1  synchronous abort of an operation in progress.
- q_in  input  W  q outputs of the JK bank.
- j  output  W  J excitation to the bank; combinational from state and q_in.
- k  output  W  K excitation to the bank; combinational from state and q_in.
- busy  output  1  high in STEP, LOAD, VERIFY.
- done  output  1  registered one-cycle success pulse.
- err  output  1  registered one-cycle failure pulse (timeout or verify mismatch).

Behaviour:
- Reset:
  - state = IDLE, tgt_r = 0, step_cnt = 0, done = 0, err = 0.
  - j = k = 0, busy = 0, cmd_ready = 0 while reset is high.
- Accept: a command is accepted on any rising edge with cmd_valid & cmd_ready. The edge latches tgt_r, mode and dir_up = (cmd_target > q_in, unsigned).
- IDLE:
  - j = k = 0 (bank holds).
  - Accept with mode 0: if cmd_target == q_in, go to IDLE and pulse done next cycle (zero steps). Otherwise go to STEP with step_cnt = 0.
  - Accept with mode 1: go to LOAD.
- STEP:
  - Each cycle, if q_in != tgt_r: nxt = q_in + 1 if dir_up, else q_in − 1, modulo 2^W. Drive toggle form j = k = nxt ^ q_in, and increment step_cnt.
  - If q_in == tgt_r: drive j = k = 0; the next edge gives done = 1 and state = IDLE.
  - If q_in != tgt_r and step_cnt == MAX_STEPS: drive j = k = 0; the next edge gives err = 1 and state = IDLE.
  - The match check takes priority over the timeout check.
- LOAD: one cycle driving j = tgt_r, k = ~tgt_r. The next edge goes to VERIFY.
- VERIFY: j = k = 0. At the next edge:
  - q_in == tgt_r → done = 1;
  - otherwise → err = 1;
  - state → IDLE in both cases.
- Latency:
  - Step mode: done rises |target − q_at_accept| + 1 edges after the accept edge.
  - Load mode: done rises 2 edges after the accept edge.
- abort:
  - In STEP, LOAD or VERIFY: j = k = 0 combinationally in that cycle; the next edge goes to IDLE with no done or err pulse.
  - In IDLE, abort is ignored.
  - If abort and cmd_valid are both high in IDLE, the command is still accepted.
- done and err are never high in the same cycle; each is high for exactly one cycle.
- A new command can be accepted in the same cycle that done or err is high, since the state is already IDLE.
- Reset mid-operation: everything returns to the reset values above on that edge; the operation in progress is discarded.
- q_in changing externally during STEP: the controller recomputes from the current q_in every cycle; dir_up is not re-evaluated; the timeout bounds the operation.

Test Plan:
- Reset, then an idle cycle → j = k = 0, busy = 0, done = err = 0. After reset drops, cmd_ready = 1.
- Step up, q = 3, target = 6 → bank goes 3→4→5→6 on successive edges; done pulses on the 4th edge after accept; busy is high for 4 cycles.
- Step down, q = 9, target = 2 → 7 decrement edges, each with j = k = nxt ^ q (first step j = k = 4'b0001). done pulses on the 8th edge.
- Load, q = 5, target = 10 → LOAD cycle shows j = 4'b1010, k = 4'b0101; q = 10 after the next edge; done on the 2nd edge. With q_in forced to 0 in VERIFY → err instead of done.
- Timeout, MAX_STEPS = 3, q = 0, target = 8 → after 3 steps q = 3; next edge err = 1, then state is IDLE.
- Abort on the 2nd STEP cycle (q = 0 → target 5) → j = k = 0 in that cycle; q holds at 1; no done or err; cmd_ready = 1 the next cycle.

Source files
------------

// File: rtl/jk_step_ctrl_if.sv
// Command/status bundle between a requester and jk_step_ctrl.
// The requester (master) presents a target and a mode with a valid/ready
// handshake, may abort a running operation, and watches busy/done/err.
interface jk_step_ctrl_if #(
   parameter int W = 4
) ();

   logic         cmd_valid;
   logic         cmd_ready;
   logic [W-1:0] cmd_target;
   logic         cmd_mode;
   logic         abort;
   logic         busy;
   logic         done;
   logic         err;

   modport master (
      output cmd_valid,
      output cmd_target,
      output cmd_mode,
      output abort,
      input  cmd_ready,
      input  busy,
      input  done,
      input  err
   );

   modport slave (
      input  cmd_valid,
      input  cmd_target,
      input  cmd_mode,
      input  abort,
      output cmd_ready,
      output busy,
      output done,
      output err
   );

endinterface

// File: rtl/jk_step_ctrl.sv
// jk_step_ctrl: drives the j/k inputs of a W-bit bank of JK flip-flops so
// that the bank's q reaches a commanded target.
//   step mode : the bank counts by one per clock toward the target, bounded
//               by MAX_STEPS excitation cycles.
//   load mode : one set/reset cycle (j = target, k = ~target), then one
//               cycle to read q back and confirm it matches.
// Completion is a one-cycle done pulse, failure a one-cycle err pulse.
module jk_step_ctrl #(
   parameter int W         = 4,
   parameter int MAX_STEPS = 16
) (
   input  logic          clk,
   input  logic          reset,
   jk_step_ctrl_if.slave cmd,
   input  logic [W-1:0]  q_in,
   output logic [W-1:0]  j,
   output logic [W-1:0]  k
);

   // Wide enough to hold MAX_STEPS itself, the value that ends a step run.
   localparam int CNT_W = $clog2(MAX_STEPS + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP   = 2'd1,
      LOAD   = 2'd2,
      VERIFY = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [W-1:0]       tgt_r;
   logic [W-1:0]       tgt_nxt;
   logic               dir_up;
   logic               dir_up_nxt;
   logic [CNT_W-1:0]   step_cnt;
   logic [CNT_W-1:0]   step_cnt_nxt;
   logic               done_r;
   logic               done_nxt;
   logic               err_r;
   logic               err_nxt;
   logic [W-1:0]       j_nxt;
   logic [W-1:0]       k_nxt;

   logic               accept;
   logic               at_target;
   logic               timed_out;
   logic [W-1:0]       step_q;

   // Handshake and status. reset masks ready/busy so the bank and the
   // requester see a quiet controller for the whole reset cycle.
   assign cmd.cmd_ready = (state == IDLE) & ~reset;
   assign cmd.busy      = (state != IDLE) & ~reset;
   assign cmd.done      = done_r;
   assign cmd.err       = err_r;

   assign accept    = cmd.cmd_valid & cmd.cmd_ready;
   assign at_target = (q_in == tgt_r);
   assign timed_out = (step_cnt == CNT_W'(MAX_STEPS));

   // Value the bank should hold after this step; wraps modulo 2^W. The
   // direction was fixed at accept and is deliberately not re-derived if
   // q_in is disturbed mid-run: the step budget bounds such a run.
   assign step_q = dir_up ? (q_in + W'(1)) : (q_in - W'(1));

   // Next-state, excitation and pulse decode.
   always_comb begin
      // NOTE: every output of this block gets a default before the case so
      // that no path leaves a signal unassigned, which would infer a latch.
      state_nxt    = state;
      tgt_nxt      = tgt_r;
      dir_up_nxt   = dir_up;
      step_cnt_nxt = step_cnt;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
      j_nxt        = '0;
      k_nxt        = '0;

      unique case (state)
         IDLE: begin
            // abort is meaningless here; a command arriving with it is
            // still taken.
            if (accept) begin
               tgt_nxt    = cmd.cmd_target;
               dir_up_nxt = (cmd.cmd_target > q_in);
               if (cmd.cmd_mode) begin
                  state_nxt = LOAD;
               end else if (cmd.cmd_target == q_in) begin
                  // Already there: report success without leaving IDLE.
                  done_nxt = 1'b1;
               end else begin
                  state_nxt    = STEP;
                  step_cnt_nxt = '0;
               end
            end
         end

         STEP: begin
            if (cmd.abort) begin
               state_nxt = IDLE;
            end else if (at_target) begin
               // Match is tested before the budget so that reaching the
               // target on the last allowed step is still a success.
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (timed_out) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               // Toggle exactly the bits that differ between q and the next
               // count value: j = k = 1 toggles, j = k = 0 holds.
               j_nxt        = step_q ^ q_in;
               k_nxt        = step_q ^ q_in;
               step_cnt_nxt = step_cnt + CNT_W'(1);
            end
         end

         LOAD: begin
            if (cmd.abort) begin
               state_nxt = IDLE;
            end else begin
               // j=1,k=0 sets and j=0,k=1 clears: the bank takes the target
               // in one edge regardless of its present value.
               j_nxt     = tgt_r;
               k_nxt     = ~tgt_r;
               state_nxt = VERIFY;
            end
         end

         VERIFY: begin
            if (cmd.abort) begin
               state_nxt = IDLE;
            end else begin
               done_nxt  = at_target;
               err_nxt   = ~at_target;
               state_nxt = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase

      // The bank shares this reset, so hold it quiet during reset.
      if (reset) begin
         j_nxt = '0;
         k_nxt = '0;
      end
   end

   assign j = j_nxt;
   assign k = k_nxt;

   // State, command and pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: registered state is updated with non-blocking assignments so
      // every flop samples pre-edge values, independent of statement order.
      if (reset) begin
         state    <= IDLE;
         tgt_r    <= '0;
         dir_up   <= 1'b0;
         step_cnt <= '0;
         done_r   <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state    <= state_nxt;
         tgt_r    <= tgt_nxt;
         dir_up   <= dir_up_nxt;
         step_cnt <= step_cnt_nxt;
         done_r   <= done_nxt;
         err_r    <= err_nxt;
      end
   end

endmodule

// File: tb/tb_jk_step_ctrl.sv
// Bench for jk_step_ctrl: a behavioural JK bank closes the loop, a vector
// table drives whole commands, and a scoreboard pairs each done/err pulse
// with the outcome, latency, final q and busy length expected for it.
module tb_jk_step_ctrl;

   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic [W-1:0] q_bank, q_in, j, k;
   logic [W-1:0] q_bank_t, j_t, k_t;
   logic         pre_en;
   logic [W-1:0] pre_val;
   logic         force0;

   jk_step_ctrl_if #(.W(W)) bus ();
   jk_step_ctrl_if #(.W(W)) bus_t ();

   jk_step_ctrl #(.W(W), .MAX_STEPS(16)) dut (
      .clk   (clk),
      .reset (reset),
      .cmd   (bus),
      .q_in  (q_in),
      .j     (j),
      .k     (k)
   );

   jk_step_ctrl #(.W(W), .MAX_STEPS(3)) dut_t (
      .clk   (clk),
      .reset (reset),
      .cmd   (bus_t),
      .q_in  (q_bank_t),
      .j     (j_t),
      .k     (k_t)
   );

   // JK bank models: Q+ = J & ~Q | ~K & Q. The main bank can be preloaded
   // and its read-back forced to zero.
   always @(posedge clk) begin
      if (reset)       q_bank <= '0;
      else if (pre_en) q_bank <= pre_val;
      else             q_bank <= (j & ~q_bank) | (~k & q_bank);
   end
   assign q_in = force0 ? '0 : q_bank;

   always @(posedge clk) begin
      if (reset) q_bank_t <= '0;
      else       q_bank_t <= (j_t & ~q_bank_t) | (~k_t & q_bank_t);
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      string        name;
      int           acc_cyc;
      int           lat;
      logic         exp_err;
      logic [W-1:0] exp_q;
      int           exp_busy;
   } exp_t;

   exp_t sb[$];
   int   busy_cnt = 0;

   // Scoreboard: on each done/err pulse, pop the oldest expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.done || bus.err) begin
            check("done_err_exclusive", {31'b0, bus.done & bus.err}, 32'd0);
            check("pulse_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check({e.name, "_outcome_err"}, {31'b0, bus.err}, {31'b0, e.exp_err});
               check({e.name, "_latency"}, cyc - e.acc_cyc, e.lat);
               check({e.name, "_final_q"}, {28'b0, q_bank}, {28'b0, e.exp_q});
               check({e.name, "_busy_cycles"}, busy_cnt, e.exp_busy);
            end
         end else if (bus.busy) begin
            busy_cnt++;
         end
         if (bus.cmd_valid && bus.cmd_ready) busy_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [W-1:0] v);
      pre_en  = 1'b1;
      pre_val = v;
      tick();
      pre_en  = 1'b0;
   endtask

   // Present one command for one cycle; it must be accepted at that edge.
   task automatic issue(input string name, input logic [W-1:0] tgt, input logic mode,
                        input bit push, input int lat, input logic exp_err,
                        input logic [W-1:0] exp_q, input int exp_busy);
      exp_t e;
      bus.cmd_valid  = 1'b1;
      bus.cmd_target = tgt;
      bus.cmd_mode   = mode;
      @(negedge clk);
      check({name, "_ready"}, {31'b0, bus.cmd_ready}, 32'd1);
      if (push) begin
         e.name     = name;
         e.acc_cyc  = cyc + 1;
         e.lat      = lat;
         e.exp_err  = exp_err;
         e.exp_q    = exp_q;
         e.exp_busy = exp_busy;
         sb.push_back(e);
      end
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
      check({name, "_drained"}, sb.size(), 32'd0);
      sb.delete();
      tick();
   endtask

   typedef struct {
      string        name;
      logic         mode;
      logic [W-1:0] start_q;
      logic [W-1:0] target;
      int           lat;
      logic         exp_err;
      logic [W-1:0] exp_q;
      int           exp_busy;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"step_up_3_6",    1'b0, 4'd3,  4'd6,  4,  1'b0, 4'd6,  4};
      vecs[1] = '{"step_up_2_12",   1'b0, 4'd2,  4'd12, 11, 1'b0, 4'd12, 11};
      vecs[2] = '{"step_down_14_1", 1'b0, 4'd14, 4'd1,  14, 1'b0, 4'd1,  14};
      vecs[3] = '{"step_up_0_15",   1'b0, 4'd0,  4'd15, 16, 1'b0, 4'd15, 16};
      vecs[4] = '{"step_zero_7",    1'b0, 4'd7,  4'd7,  0,  1'b0, 4'd7,  0};
      vecs[5] = '{"load_15_0",      1'b1, 4'd15, 4'd0,  2,  1'b0, 4'd0,  2};

      reset = 1'b1;
      pre_en = 1'b0; pre_val = '0; force0 = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_target = '0; bus.cmd_mode = 1'b0; bus.abort = 1'b0;
      bus_t.cmd_valid = 1'b0; bus_t.cmd_target = '0; bus_t.cmd_mode = 1'b0; bus_t.abort = 1'b0;

      // Reset state.
      repeat (2) tick();
      @(negedge clk);
      check("rst_j", {28'b0, j}, 32'd0);
      check("rst_k", {28'b0, k}, 32'd0);
      check("rst_busy", {31'b0, bus.busy}, 32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_err", {31'b0, bus.err}, 32'd0);
      check("rst_ready_low", {31'b0, bus.cmd_ready}, 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);

      // Timeout on the MAX_STEPS=3 instance: 0 -> 8 stalls at 3, then err.
      tick();
      bus_t.cmd_valid = 1'b1; bus_t.cmd_target = 4'd8; bus_t.cmd_mode = 1'b0;
      tick();
      bus_t.cmd_valid = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("tmo_q_after_3", {28'b0, q_bank_t}, 32'd3);
      check("tmo_j_quiet", {28'b0, j_t}, 32'd0);
      check("tmo_busy", {31'b0, bus_t.busy}, 32'd1);
      tick();
      @(negedge clk);
      check("tmo_err", {31'b0, bus_t.err}, 32'd1);
      check("tmo_no_done", {31'b0, bus_t.done}, 32'd0);
      check("tmo_idle_ready", {31'b0, bus_t.cmd_ready}, 32'd1);
      tick();
      @(negedge clk);
      check("tmo_err_one_cycle", {31'b0, bus_t.err}, 32'd0);
      tick();

      // Table of whole commands checked by the scoreboard.
      for (int i = 0; i < 6; i++) begin
         preload(vecs[i].start_q);
         issue(vecs[i].name, vecs[i].target, vecs[i].mode, 1'b1, vecs[i].lat,
               vecs[i].exp_err, vecs[i].exp_q, vecs[i].exp_busy);
         wait_drain(vecs[i].name);
      end

      // Step down 9 -> 2: first excitation is 4'b0001, then q walks down.
      preload(4'd9);
      issue("down_9_2", 4'd2, 1'b0, 1'b1, 8, 1'b0, 4'd2, 8);
      @(negedge clk);
      check("down_first_j", {28'b0, j}, 32'd1);
      check("down_first_k", {28'b0, k}, 32'd1);
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         check("down_q_walk", {28'b0, q_bank}, 32'(9 - i));
      end
      wait_drain("down_9_2");

      // Load 5 -> 10: one set/reset cycle.
      preload(4'd5);
      issue("load_5_10", 4'd10, 1'b1, 1'b1, 2, 1'b0, 4'd10, 2);
      @(negedge clk);
      check("load_j", {28'b0, j}, 32'hA);
      check("load_k", {28'b0, k}, 32'h5);
      wait_drain("load_5_10");

      // Load with read-back forced to 0 during VERIFY -> err.
      preload(4'd5);
      issue("load_bad_verify", 4'd10, 1'b1, 1'b1, 2, 1'b1, 4'd10, 2);
      tick();
      force0 = 1'b1;
      tick();
      force0 = 1'b0;
      wait_drain("load_bad_verify");

      // Abort on the 2nd STEP cycle of 0 -> 5.
      preload(4'd0);
      issue("abort_step", 4'd5, 1'b0, 1'b0, 0, 1'b0, 4'd0, 0);
      tick();
      bus.abort = 1'b1;
      @(negedge clk);
      check("abort_j_quiet", {28'b0, j}, 32'd0);
      check("abort_k_quiet", {28'b0, k}, 32'd0);
      tick();
      bus.abort = 1'b0;
      @(negedge clk);
      check("abort_q_hold", {28'b0, q_bank}, 32'd1);
      check("abort_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check("abort_no_done", {31'b0, bus.done}, 32'd0);
      check("abort_no_err", {31'b0, bus.err}, 32'd0);
      repeat (3) tick();
      check("abort_q_still", {28'b0, q_bank}, 32'd1);

      // Abort in IDLE alongside a command: the command is taken.
      preload(4'd4);
      bus.abort = 1'b1;
      issue("abort_idle_accept", 4'd6, 1'b0, 1'b1, 3, 1'b0, 4'd6, 3);
      bus.abort = 1'b0;
      wait_drain("abort_idle_accept");

      // Back-to-back: next command accepted in the done cycle.
      preload(4'd1);
      issue("b2b_first", 4'd3, 1'b0, 1'b1, 3, 1'b0, 4'd3, 3);
      repeat (3) tick();
      issue("b2b_second", 4'd1, 1'b0, 1'b1, 3, 1'b0, 4'd1, 3);
      wait_drain("b2b");

      // Reset in the middle of a step run.
      preload(4'd2);
      issue("mid_reset", 4'd9, 1'b0, 1'b0, 0, 1'b0, 4'd0, 0);
      repeat (2) tick();
      reset = 1'b1;
      @(negedge clk);
      check("mrst_j", {28'b0, j}, 32'd0);
      check("mrst_busy", {31'b0, bus.busy}, 32'd0);
      check("mrst_ready", {31'b0, bus.cmd_ready}, 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("mrst_q", {28'b0, q_bank}, 32'd0);
      check("mrst_idle_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check("mrst_no_done", {31'b0, bus.done}, 32'd0);
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
